// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue: single outstanding memory read feeding
// a small FIFO of {pc, instruction} entries, with redirect flush.
module fetch_queue_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int INC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_moc,
  input  logic [DATA_W-1:0] mem_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] INC_A = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN =
    ~(ADDR_W'(INC) - ADDR_W'(1));
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] ir_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic issue;
  logic push;
  logic pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // moc wins over redirect in WAIT: the request is retired either way
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: begin
        if (issue) state_nx = WAIT;
      end
      state == WAIT: begin
        if (mem_moc) state_nx = IDLE;
        else if (redirect) state_nx = DRAIN;
      end
      state == DRAIN: begin
        if (mem_moc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    issue   = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        issue   = !reset && !redirect
                  && (count < FULL);
        mem_req = issue;
      end
      WAIT: begin
        mem_req = !reset;
        push    = mem_moc && !redirect;
      end
      DRAIN: begin
        mem_req = !reset;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign pop = (count != '0) && ir_ready;

  // a redirect may retarget fpc while a stale read is still pending
  assign mem_addr = (state == IDLE) ? fpc : req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        ir_q[i] <= '0;
      end
    end else begin
      if (issue) req_addr <= fpc;
      if (redirect) begin
        fpc    <= redirect_addr & ALIGN;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_q[wr_ptr] <= req_addr;
          ir_q[wr_ptr] <= mem_data;
          wr_ptr       <= wr_ptr + PW'(1);
          fpc          <= fpc + INC_A;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assign ir_valid = (count != '0);
  assign ir_out   = ir_q[rd_ptr];
  assign ir_pc    = pc_q[rd_ptr];
  assign q_count  = count;

endmodule
